// File: rtl/spi_adc_scan_sequencer.sv
// Scans a 3-channel 10-bit SPI ADC through a byte-level SPI master.
// Each completed scan updates three PWM duty words; an RX watchdog aborts stalled transactions.
`timescale 1ns/1ps
module spi_adc_scan_sequencer #(
    parameter int SCAN_PERIOD = 100000,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int RX_TIMEOUT  = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    output logic [7:0] o_TX_Byte,
    output logic       o_TX_DV,
    input  logic       i_TX_Ready,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_CS_n,
    output logic [9:0] o_duty0,
    output logic [9:0] o_duty1,
    output logic [9:0] o_duty2,
    output logic       o_duty_valid,
    output logic       o_error
);

    localparam int PACE_W  = $clog2(SCAN_PERIOD);
    localparam int WDOG_W  = $clog2(RX_TIMEOUT + 1);
    localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_WAIT_RX,
        ST_HOLD,
        ST_UPDATE
    } state_t;

    state_t              state_r;
    logic [PACE_W-1:0]   pace_r;
    logic [WDOG_W-1:0]   wdog_r;
    logic [GAP_W-1:0]    gap_r;
    logic [1:0]          ch_r;
    logic [1:0]          byte_r;
    logic [1:0]          rx_hi_r;
    logic [9:0]          shadow0_r;
    logic [9:0]          shadow1_r;
    logic [9:0]          shadow2_r;
    logic                abort_r;
    logic                start_s;

    // MCP3008 framing: start bit, single-ended channel select, then a dummy byte
    function automatic logic [7:0] cmd_byte(input logic [1:0] ch, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h01;
            2'd1:    b = {1'b1, 1'b0, ch, 4'b0000};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign start_s = (state_r == ST_IDLE) && (pace_r == PACE_W'(0)) && i_enable;

    // Scan pacing: reload on scan start, count down and saturate at zero
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pace_r <= PACE_W'(0);
        end else if (start_s) begin
            pace_r <= PACE_W'(SCAN_PERIOD - 1);
        end else if (pace_r != PACE_W'(0)) begin
            pace_r <= pace_r - PACE_W'(1);
        end else begin
            pace_r <= pace_r;
        end
    end

    // Scan sequencer with registered SPI handshake, chip select and duty outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r      <= ST_IDLE;
            o_CS_n       <= 1'b1;
            o_TX_DV      <= 1'b0;
            o_TX_Byte    <= 8'h00;
            o_duty0      <= 10'd0;
            o_duty1      <= 10'd0;
            o_duty2      <= 10'd0;
            o_duty_valid <= 1'b0;
            o_error      <= 1'b0;
            wdog_r       <= WDOG_W'(0);
            gap_r        <= GAP_W'(0);
            ch_r         <= 2'd0;
            byte_r       <= 2'd0;
            rx_hi_r      <= 2'd0;
            shadow0_r    <= 10'd0;
            shadow1_r    <= 10'd0;
            shadow2_r    <= 10'd0;
            abort_r      <= 1'b0;
        end else begin
            o_TX_DV      <= 1'b0;
            o_duty_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        o_CS_n  <= 1'b0;
                        gap_r   <= GAP_W'(0);
                        ch_r    <= 2'd0;
                        byte_r  <= 2'd0;
                        abort_r <= 1'b0;
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (gap_r == GAP_W'(CS_SETUP - 1)) begin
                        gap_r   <= GAP_W'(0);
                        state_r <= ST_LAUNCH;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    if (i_TX_Ready) begin
                        o_TX_DV   <= 1'b1;
                        o_TX_Byte <= cmd_byte(ch_r, byte_r);
                        wdog_r    <= WDOG_W'(0);
                        state_r   <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (i_RX_DV) begin
                        if (byte_r == 2'd1) begin
                            rx_hi_r <= i_RX_Byte[1:0];
                        end
                        if (byte_r == 2'd2) begin
                            case (ch_r)
                                2'd0:    shadow0_r <= {rx_hi_r, i_RX_Byte};
                                2'd1:    shadow1_r <= {rx_hi_r, i_RX_Byte};
                                default: shadow2_r <= {rx_hi_r, i_RX_Byte};
                            endcase
                            o_CS_n  <= 1'b1;
                            gap_r   <= GAP_W'(0);
                            state_r <= ST_HOLD;
                        end else begin
                            byte_r  <= byte_r + 2'd1;
                            state_r <= ST_LAUNCH;
                        end
                    end else if (wdog_r == WDOG_W'(RX_TIMEOUT - 1)) begin
                        // Abort the whole scan: partial results must never reach the duties
                        o_error   <= 1'b1;
                        o_CS_n    <= 1'b1;
                        abort_r   <= 1'b1;
                        shadow0_r <= 10'd0;
                        shadow1_r <= 10'd0;
                        shadow2_r <= 10'd0;
                        gap_r     <= GAP_W'(0);
                        state_r   <= ST_HOLD;
                    end else begin
                        wdog_r <= wdog_r + WDOG_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (gap_r == GAP_W'(CS_HOLD - 1)) begin
                        gap_r <= GAP_W'(0);
                        if (abort_r) begin
                            state_r <= ST_IDLE;
                        end else if (ch_r == 2'd2) begin
                            // Duties and strobe are loaded on the edge entering UPDATE
                            o_duty0      <= shadow0_r;
                            o_duty1      <= shadow1_r;
                            o_duty2      <= shadow2_r;
                            o_duty_valid <= 1'b1;
                            state_r      <= ST_UPDATE;
                        end else begin
                            ch_r    <= ch_r + 2'd1;
                            byte_r  <= 2'd0;
                            o_CS_n  <= 1'b0;
                            state_r <= ST_SETUP;
                        end
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                ST_UPDATE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_CS_n  <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
